cache_steal_ctrl: RTL
=====================

Name: cache_steal_ctrl

Overview:
- Parametrised successor to the fixed three-region cache access steerer.
- Decodes the top address bits of each CPU access into one of NUM_REGIONS regions.
- Issues a one-cycle read or write strobe to that region's cache port and stalls the CPU until the region returns valid.
- Adds per-region read/write permission masks, a wait timeout with a sticky error, and a saturating completed-transaction counter.
- Sits between the CPU memory stage and the instruction/data caches fed by the memory controller.

Parameters:
ADDR_W, 32, CPU address width.
REGION_BITS, 2, number of top address bits used as region index; NUM_REGIONS = 2**REGION_BITS.
RD_MASK, 4'b0011, bit r set means region r permits reads.
WR_MASK, 4'b0100, bit r set means region r permits writes.
TIMEOUT, 255, maximum WAIT cycles before error; must be at least 1.
CNT_W, 16, width of the transaction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  gates acceptance of new requests only.
cpu_re  in  1  CPU read request, level, held until stall drops.
cpu_we  in  1  CPU write request, level, held until stall drops.
cpu_addr  in  ADDR_W  CPU address; region = cpu_addr[ADDR_W-1 -: REGION_BITS].
rd_valid  in  NUM_REGIONS  per-region read data valid.
wr_valid  in  NUM_REGIONS  per-region write accepted.
clr_err  in  1  clears sticky error.
cache_re  out  NUM_REGIONS  one-hot read strobe, registered.
cache_we  out  NUM_REGIONS  one-hot write strobe, registered.
stall  out  1  CPU stall, combinational.
done  out  1  one-cycle completion pulse, combinational.
err  out  1  sticky error flag, registered.
err_code  out  2  error cause: 01 illegal access, 10 timeout; 00 otherwise.
err_region  out  REGION_BITS  region of the faulting access.
txn_cnt  out  CNT_W  completed transactions, saturating.

Behaviour:
- Reset: async on rst_n low. State goes to IDLE; cache_re, cache_we, err, err_code, err_region, txn_cnt and the wait counter all clear to 0. A reset mid-transaction abandons it with no strobe or done.
- Qualified request: en & (cpu_re | cpu_we) while in IDLE.
- Illegal request, evaluated in IDLE:
  - cpu_re & cpu_we both high;
  - read to a region with RD_MASK bit 0;
  - write to a region with WR_MASK bit 0.
- IDLE:
  - No qualified request: stall=0.
  - Legal qualified request: stall=1; latch region and direction; next state REQ.
  - Illegal qualified request: stall=1; next state ERR; err<=1, err_code<=01, err_region<=region.
- REQ, exactly one cycle:
  - Exactly one bit of cache_re or cache_we is high, at the latched region.
  - The matching valid bit is sampled this cycle. If high: done=1, stall=0, next state IDLE. Otherwise stall=1, wait counter <= 1, next state WAIT.
- WAIT:
  - cache_re and cache_we are 0.
  - Matching valid high: done=1, stall=0, next state IDLE.
  - Else if wait counter == TIMEOUT: next state ERR; err<=1, err_code<=10, err_region<=latched region; stall=1.
  - Else: counter increments, stall=1.
- ERR:
  - stall=1, no strobes issued.
  - clr_err high: err, err_code and err_region clear next edge, next state IDLE. stall is still 1 in that cycle.
- Valid bits of non-latched regions and of the opposite direction are ignored at all times.
- en dropping mid-transaction has no effect; the transaction completes or times out normally.
- txn_cnt increments on every done pulse and holds at all-ones.
- Latency: minimum stall is 1 cycle (request cycle). With valid in the REQ cycle, done asserts 1 cycle after the request is first seen.
- Back-to-back: after done, the next request can be accepted in the following IDLE cycle. This leaves one non-stalled cycle between transactions.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately. Assert no cache_re after release.
- Read, region 0, rd_valid[0] high in REQ -> cycle0 stall=1; cycle1 cache_re=4'b0001, done=1, stall=0; txn_cnt=1.
- Write, region 2, wr_valid[2] arrives 3 cycles after REQ -> cache_we=4'b0100 for exactly one cycle; stall held 4 cycles; single done; wr_valid[1] pulses during WAIT are ignored.
- Illegal: write to region 0 -> err=1, err_code=01, err_region=0, no strobe, stall held. clr_err -> err=0, IDLE next cycle.
- Timeout: TIMEOUT=4, read region 1, no rd_valid -> err_code=10, err_region=1 after 4 WAIT cycles; txn_cnt unchanged.
- Saturation: CNT_W=2, 5 completed reads -> txn_cnt sticks at 3. Also cover cpu_re & cpu_we together -> err_code=01.

Source files
------------

// File: rtl/cache_steal_ctrl_if.sv
// Bus between the CPU memory stage and cache_steal_ctrl.
// master: CPU side, drives requests and cache valid returns, observes strobes/status.
// slave:  controller side.
// Signals: en, cpu_re, cpu_we, cpu_addr, rd_valid, wr_valid, clr_err (to controller);
//          cache_re, cache_we, stall, done, err, err_code, err_region, txn_cnt (from controller).
interface cache_steal_ctrl_if #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REGION_BITS = 2,
  parameter int unsigned CNT_W       = 16
);
  localparam int unsigned NumRegions = 2 ** REGION_BITS;

  logic                   en;
  logic                   cpu_re;
  logic                   cpu_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [NumRegions-1:0]  rd_valid;
  logic [NumRegions-1:0]  wr_valid;
  logic                   clr_err;
  logic [NumRegions-1:0]  cache_re;
  logic [NumRegions-1:0]  cache_we;
  logic                   stall;
  logic                   done;
  logic                   err;
  logic [1:0]             err_code;
  logic [REGION_BITS-1:0] err_region;
  logic [CNT_W-1:0]       txn_cnt;

  modport master (
    output en, cpu_re, cpu_we, cpu_addr, rd_valid, wr_valid, clr_err,
    input  cache_re, cache_we, stall, done, err, err_code, err_region, txn_cnt
  );

  modport slave (
    input  en, cpu_re, cpu_we, cpu_addr, rd_valid, wr_valid, clr_err,
    output cache_re, cache_we, stall, done, err, err_code, err_region, txn_cnt
  );
endinterface

// File: rtl/cache_steal_ctrl.sv
// Steers CPU accesses to one of 2**REGION_BITS cache regions chosen by the top address bits.
// Issues a registered one-cycle read/write strobe to the region, stalls the CPU until the
// region's matching valid returns, enforces per-region permissions, times out waits with a
// sticky error, and counts completed transactions (saturating).
// Ports: clk, rst_n (async, active low), bus (cache_steal_ctrl_if.slave).
module cache_steal_ctrl #(
  parameter int unsigned                  ADDR_W      = 32,
  parameter int unsigned                  REGION_BITS = 2,
  parameter logic [2**REGION_BITS-1:0]    RD_MASK     = 4'b0011,
  parameter logic [2**REGION_BITS-1:0]    WR_MASK     = 4'b0100,
  parameter int unsigned                  TIMEOUT     = 255,
  parameter int unsigned                  CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  cache_steal_ctrl_if.slave bus
);
  localparam int unsigned NumRegions = 2 ** REGION_BITS;
  localparam int unsigned WaitW      = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  CodeIllegal = 2'b01;
  localparam logic [1:0]  CodeTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StErr} state_e;

  state_e                 state_q, state_d;
  logic [REGION_BITS-1:0] region_q, region_d;
  logic                   is_wr_q, is_wr_d;
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [NumRegions-1:0]  cache_re_q, cache_re_d;
  logic [NumRegions-1:0]  cache_we_q, cache_we_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [REGION_BITS-1:0] err_region_q, err_region_d;
  logic [CNT_W-1:0]       txn_cnt_q, txn_cnt_d;

  logic [REGION_BITS-1:0] region;
  logic [NumRegions-1:0]  region_oh;
  logic                   req_qual;
  logic                   illegal;
  logic                   valid_hit;
  logic                   stall;
  logic                   done;

  assign region    = bus.cpu_addr[ADDR_W-1 -: REGION_BITS];
  assign region_oh = NumRegions'(1) << region;
  assign req_qual  = bus.en & (bus.cpu_re | bus.cpu_we);
  assign illegal   = (bus.cpu_re & bus.cpu_we) |
                     (bus.cpu_re & ~RD_MASK[region]) |
                     (bus.cpu_we & ~WR_MASK[region]);
  // Only the latched region and direction can complete a transaction.
  assign valid_hit = is_wr_q ? bus.wr_valid[region_q] : bus.rd_valid[region_q];

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    is_wr_d      = is_wr_q;
    wait_cnt_d   = wait_cnt_q;
    cache_re_d   = '0;
    cache_we_d   = '0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    err_region_d = err_region_q;
    stall        = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_qual) begin
          stall = 1'b1;
          if (illegal) begin
            state_d      = StErr;
            err_d        = 1'b1;
            err_code_d   = CodeIllegal;
            err_region_d = region;
          end else begin
            state_d    = StReq;
            region_d   = region;
            is_wr_d    = bus.cpu_we;
            cache_re_d = bus.cpu_we ? '0 : region_oh;
            cache_we_d = bus.cpu_we ? region_oh : '0;
          end
        end
      end
      StReq: begin
        if (valid_hit) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = WaitW'(1);
          state_d    = StWait;
        end
      end
      StWait: begin
        if (valid_hit) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (wait_cnt_q == WaitW'(TIMEOUT)) begin
          stall        = 1'b1;
          state_d      = StErr;
          err_d        = 1'b1;
          err_code_d   = CodeTimeout;
          err_region_d = region_q;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr: begin
        stall = 1'b1;
        if (bus.clr_err) begin
          err_d        = 1'b0;
          err_code_d   = '0;
          err_region_d = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (done && (txn_cnt_q != '1)) txn_cnt_d = txn_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      region_q     <= '0;
      is_wr_q      <= 1'b0;
      wait_cnt_q   <= '0;
      cache_re_q   <= '0;
      cache_we_q   <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      err_region_q <= '0;
      txn_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      is_wr_q      <= is_wr_d;
      wait_cnt_q   <= wait_cnt_d;
      cache_re_q   <= cache_re_d;
      cache_we_q   <= cache_we_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_region_q <= err_region_d;
      txn_cnt_q    <= txn_cnt_d;
    end
  end

  assign bus.cache_re   = cache_re_q;
  assign bus.cache_we   = cache_we_q;
  assign bus.stall      = stall;
  assign bus.done       = done;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.err_region = err_region_q;
  assign bus.txn_cnt    = txn_cnt_q;
endmodule
